// File: rtl/player_kinematics.sv
// Player motion for one sprite: walks, jumps and falls on each game tick.
// Produces a registered position, a sprite index and an airborne flag.
module player_kinematics #(
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 1023,
    parameter int X_START   = 64,
    parameter int GROUND_Y  = 400,
    parameter int WALK_V    = 4,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int VMAX_FALL = 8,
    parameter int JUMP_HOLD = 6,
    parameter int ANIM_DIV  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           jump,
    input  logic           left,
    input  logic           right,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [5:0]     sprite_id,
    output logic           airborne
);

    localparam int HW = $clog2(JUMP_HOLD + 1);
    localparam int AW = $clog2(ANIM_DIV + 1);

    localparam logic [X_W:0]   XMIN_E  = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]   XMAX_E  = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]   WALK_E  = (X_W+1)'(WALK_V);
    localparam logic [Y_W-1:0] GY      = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0] JV      = Y_W'(JUMP_V);
    localparam logic [Y_W-1:0] GR      = Y_W'(GRAVITY);
    localparam logic [Y_W-1:0] VMX     = Y_W'(VMAX_FALL);
    localparam logic [HW-1:0]  JH      = HW'(JUMP_HOLD);
    localparam logic [AW-1:0]  AD      = AW'(ANIM_DIV);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    state_t         r_state;
    logic [X_W-1:0] r_pos_x;
    logic [Y_W-1:0] r_pos_y;
    logic [Y_W-1:0] r_vy;
    logic [HW-1:0]  r_hold_cnt;
    logic [AW-1:0]  r_anim_cnt;
    logic [1:0]     r_frame;
    logic           r_facing_left;
    logic           r_jump_armed;
    logic [5:0]     r_sprite_id;
    logic           r_airborne;

    state_t         w_state_n;
    logic [X_W-1:0] w_x_n;
    logic [Y_W-1:0] w_y_n;
    logic [Y_W-1:0] w_vy_n;
    logic [HW-1:0]  w_hold_n;
    logic [AW-1:0]  w_anim_n;
    logic [1:0]     w_frame_n;
    logic           w_face_n;
    logic           w_armed_n;
    logic           w_moving;
    logic [X_W:0]   w_x_inc;
    logic [X_W:0]   w_x_dec;
    logic [Y_W-1:0] w_vy_rise;
    logic [Y_W:0]   w_vy_fall_sum;
    logic [Y_W-1:0] w_vy_fall;
    logic [Y_W:0]   w_y_fall_sum;

    assign w_moving      = left ^ right;
    assign w_x_inc       = {1'b0, r_pos_x} + WALK_E;
    assign w_x_dec       = {1'b0, r_pos_x} - WALK_E;
    assign w_vy_fall_sum = {1'b0, r_vy} + {1'b0, GR};
    assign w_vy_fall     = (w_vy_fall_sum > {1'b0, VMX}) ? VMX : w_vy_fall_sum[Y_W-1:0];
    assign w_y_fall_sum  = {1'b0, r_pos_y} + {1'b0, w_vy_fall};

    always_comb begin
        w_x_n     = r_pos_x;
        w_face_n  = r_facing_left;
        w_armed_n = r_jump_armed | ~jump;
        w_state_n = r_state;
        w_y_n     = r_pos_y;
        w_vy_n    = r_vy;
        w_hold_n  = r_hold_cnt;
        w_vy_rise = r_vy;
        w_anim_n  = r_anim_cnt;
        w_frame_n = r_frame;

        // Horizontal saturates at the bounds; the extra bit catches overflow and underflow.
        if (right && !left) begin
            w_x_n    = (w_x_inc > XMAX_E) ? XMAX_E[X_W-1:0] : w_x_inc[X_W-1:0];
            w_face_n = 1'b0;
        end else if (left && !right) begin
            w_x_n    = (w_x_dec[X_W] || (w_x_dec < XMIN_E)) ? XMIN_E[X_W-1:0] : w_x_dec[X_W-1:0];
            w_face_n = 1'b1;
        end

        case (r_state)
            GROUND: begin
                if (jump && r_jump_armed) begin
                    w_y_n     = r_pos_y - JV;
                    w_vy_n    = JV;
                    w_hold_n  = HW'(1);
                    w_state_n = RISE;
                    w_armed_n = 1'b0;
                end else begin
                    w_y_n = GY;
                end
            end
            RISE: begin
                if (jump && (r_hold_cnt < JH)) begin
                    w_hold_n  = r_hold_cnt + HW'(1);
                    w_vy_rise = r_vy;
                end else begin
                    w_vy_rise = (r_vy <= GR) ? '0 : (r_vy - GR);
                end
                if (w_vy_rise == '0) begin
                    w_vy_n    = '0;
                    w_state_n = FALL;
                end else if (w_vy_rise > r_pos_y) begin
                    w_y_n     = '0;
                    w_vy_n    = '0;
                    w_state_n = FALL;
                end else begin
                    w_y_n  = r_pos_y - w_vy_rise;
                    w_vy_n = w_vy_rise;
                end
            end
            FALL: begin
                if (w_y_fall_sum >= {1'b0, GY}) begin
                    w_y_n     = GY;
                    w_vy_n    = '0;
                    w_state_n = GROUND;
                end else begin
                    w_y_n  = w_y_fall_sum[Y_W-1:0];
                    w_vy_n = w_vy_fall;
                end
            end
            default: w_state_n = GROUND;
        endcase

        // A zero anim counter marks "not walking last tick", so walking restarts at frame 1.
        if ((w_state_n != GROUND) || !w_moving) begin
            w_anim_n  = '0;
            w_frame_n = 2'd0;
        end else if (r_anim_cnt == '0) begin
            w_anim_n  = AW'(1);
            w_frame_n = 2'd1;
        end else if (r_anim_cnt >= AD) begin
            w_anim_n  = AW'(1);
            w_frame_n = (r_frame == 2'd3) ? 2'd1 : (r_frame + 2'd1);
        end else begin
            w_anim_n = r_anim_cnt + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= GROUND;
            r_pos_x       <= X_W'(X_START);
            r_pos_y       <= GY;
            r_vy          <= '0;
            r_hold_cnt    <= '0;
            r_anim_cnt    <= '0;
            r_frame       <= 2'd0;
            r_facing_left <= 1'b0;
            r_jump_armed  <= 1'b1;
            r_sprite_id   <= 6'd0;
            r_airborne    <= 1'b0;
        end else if (tick) begin
            r_state       <= w_state_n;
            r_pos_x       <= w_x_n;
            r_pos_y       <= w_y_n;
            r_vy          <= w_vy_n;
            r_hold_cnt    <= w_hold_n;
            r_anim_cnt    <= w_anim_n;
            r_frame       <= w_frame_n;
            r_facing_left <= w_face_n;
            r_jump_armed  <= w_armed_n;
            r_sprite_id   <= {w_face_n, (w_state_n != GROUND) ? 5'd4 : {3'b000, w_frame_n}};
            r_airborne    <= (w_state_n != GROUND);
        end
    end

    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign sprite_id = r_sprite_id;
    assign airborne  = r_airborne;

endmodule

// File: tb/tb_player_kinematics.sv
// Directed bench for player_kinematics: walking, jumps, bounds and reset.
// Expected values are hand-computed from the default parameters.
module tb_player_kinematics;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        jump;
    logic        left;
    logic        right;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic [5:0]  sprite_id;
    logic        airborne;

    int passCount  = 0;
    int totalCount = 0;

    player_kinematics dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .jump      (jump),
        .left      (left),
        .right     (right),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .sprite_id (sprite_id),
        .airborne  (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One game tick with the given button levels, then outputs settle for sampling.
    task automatic applyStimulus(input logic j, input logic l, input logic r);
        @(negedge clk);
        jump  = j;
        left  = l;
        right = r;
        tick  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    int spriteWalk [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    int tapFall    [14] = '{323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382, 390, 398, 400};
    int heldRise   [17] = '{388, 376, 364, 352, 340, 328, 317, 307, 298, 290, 283, 277, 272, 268, 265, 263, 262};

    initial begin
        rst = 1'b0; tick = 1'b0; jump = 1'b0; left = 1'b0; right = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_x", 32'(pos_x), 64);
        checkOutput("reset_y", 32'(pos_y), 400);
        checkOutput("reset_sprite", 32'(sprite_id), 0);
        checkOutput("reset_air", 32'(airborne), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("walk_x_%0d", i), 32'(pos_x), 32'(68 + 4 * i));
            checkOutput($sformatf("walk_sprite_%0d", i), 32'(sprite_id), 32'(spriteWalk[i]));
        end
        checkOutput("walk_y", 32'(pos_y), 400);
        checkOutput("walk_air", 32'(airborne), 0);

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_sprite", 32'(sprite_id), 0);
        checkOutput("idle_x", 32'(pos_x), 104);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tap_launch_y", 32'(pos_y), 388);
        checkOutput("tap_launch_air", 32'(airborne), 1);
        checkOutput("tap_launch_sprite", 32'(sprite_id), 4);
        repeat (11) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tap_apex_y", 32'(pos_y), 322);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tap_turn_y", 32'(pos_y), 322);
        checkOutput("tap_turn_air", 32'(airborne), 1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("tap_fall_y_%0d", i), 32'(pos_y), 32'(tapFall[i]));
        end
        checkOutput("tap_land_air", 32'(airborne), 0);
        checkOutput("tap_land_sprite", 32'(sprite_id), 0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("held_rise_y_%0d", i), 32'(pos_y), 32'(heldRise[i]));
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("held_turn_y", 32'(pos_y), 262);
        repeat (21) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("held_land_y", 32'(pos_y), 400);
        checkOutput("held_land_air", 32'(airborne), 0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("held_norelaunch_air", 32'(airborne), 0);
        checkOutput("held_norelaunch_y", 32'(pos_y), 400);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("release_air", 32'(airborne), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("repress_air", 32'(airborne), 1);
        checkOutput("repress_y", 32'(pos_y), 388);
        repeat (26) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("repress_land_y", 32'(pos_y), 400);
        checkOutput("repress_land_air", 32'(airborne), 0);

        repeat (229) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("right_1020", 32'(pos_x), 1020);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("right_sat", 32'(pos_x), 1023);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("right_stay", 32'(pos_x), 1023);
        checkOutput("right_face", 32'(sprite_id[5]), 0);

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("left_1019", 32'(pos_x), 1019);
        checkOutput("left_face", 32'(sprite_id[5]), 1);
        repeat (254) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("left_3", 32'(pos_x), 3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("left_sat", 32'(pos_x), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("left_stay", 32'(pos_x), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("both_x_%0d", i), 32'(pos_x), 0);
            checkOutput($sformatf("both_sprite_%0d", i), 32'(sprite_id), 32'h20);
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid_launch_y", 32'(pos_y), 388);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mid_rise_y", 32'(pos_y), 377);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_x", 32'(pos_x), 64);
        checkOutput("midreset_y", 32'(pos_y), 400);
        checkOutput("midreset_sprite", 32'(sprite_id), 0);
        checkOutput("midreset_air", 32'(airborne), 0);
        @(negedge clk);
        rst = 1'b1;

        jump = 1'b1; right = 1'b1; left = 1'b0; tick = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("notick_x", 32'(pos_x), 64);
        checkOutput("notick_y", 32'(pos_y), 400);
        checkOutput("notick_air", 32'(airborne), 0);
        checkOutput("notick_sprite", 32'(sprite_id), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
